// File: rtl/automata_report_stage.sv
// Report capture stage for a pipelined automata array: forwards symbols and reset to the
// next stage, accumulates report hits. Optional timestamping via AUTOMATA_RPT_TIMESTAMP_EN.
module automata_report_stage #(
  parameter  int SYM_W   = 8,
  parameter  int NUM_RPT = 36,
  parameter  int DEPTH   = 1,
  parameter  int CNT_W   = 16,
  localparam int IDX_W   = ($clog2(NUM_RPT) > 1) ? $clog2(NUM_RPT) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [SYM_W-1:0]   top_symbols,
  input  logic [NUM_RPT-1:0] rpt_in,
  input  logic               rpt_clr,
  output logic [SYM_W-1:0]   out_symbols,
  output logic               out_reset,
  output logic [NUM_RPT-1:0] rpt_sticky,
  output logic               first_valid,
  output logic [IDX_W-1:0]   first_idx,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   first_time
);

  logic [SYM_W-1:0]   sym_pipe [DEPTH];
  logic [DEPTH-1:0]   rst_pipe;

  logic               any_hit;
  logic [IDX_W-1:0]   low_idx;
  logic               capture;

  logic [NUM_RPT-1:0] base_sticky;
  logic [CNT_W-1:0]   base_hit;
  logic               base_valid;
  logic [IDX_W-1:0]   base_idx;

  // Symbol pipeline only advances with the stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        sym_pipe[i] <= '0;
      end
    end else if (run) begin
      sym_pipe[0] <= top_symbols;
      for (int i = 1; i < DEPTH; i++) begin
        sym_pipe[i] <= sym_pipe[i-1];
      end
    end
  end

  // The reset pipeline must carry reset itself, so it is deliberately never cleared.
  always_ff @(posedge clk) begin
    rst_pipe[0] <= reset;
    for (int i = 1; i < DEPTH; i++) begin
      rst_pipe[i] <= rst_pipe[i-1];
    end
  end

  assign out_symbols = sym_pipe[DEPTH-1];
  assign out_reset   = rst_pipe[DEPTH-1];

  always_comb begin
    low_idx = '0;
    for (int i = NUM_RPT - 1; i >= 0; i--) begin
      if (rpt_in[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  assign any_hit = |rpt_in;

  // A clear in the same cycle as a hit applies first, so the hit lands in clean state.
  always_comb begin
    base_sticky = rpt_clr ? '0 : rpt_sticky;
    base_hit    = rpt_clr ? '0 : hit_count;
    base_valid  = rpt_clr ? 1'b0 : first_valid;
    base_idx    = rpt_clr ? '0 : first_idx;
  end

  assign capture = run & any_hit & ~base_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_sticky  <= '0;
      hit_count   <= '0;
      first_valid <= 1'b0;
      first_idx   <= '0;
    end else begin
      if (run) begin
        rpt_sticky <= base_sticky | rpt_in;
      end else begin
        rpt_sticky <= base_sticky;
      end

      if (run && any_hit && (base_hit != '1)) begin
        hit_count <= base_hit + CNT_W'(1);
      end else begin
        hit_count <= base_hit;
      end

      if (capture) begin
        first_valid <= 1'b1;
        first_idx   <= low_idx;
      end else begin
        first_valid <= base_valid;
        first_idx   <= base_idx;
      end
    end
  end

`ifdef AUTOMATA_RPT_TIMESTAMP_EN
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] first_time_q;

  // Run-cycle counter wraps freely and ignores clears; it only restarts on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt      <= '0;
      first_time_q <= '0;
    end else begin
      if (run) begin
        run_cnt <= run_cnt + CNT_W'(1);
      end
      if (capture) begin
        first_time_q <= run_cnt;
      end else if (rpt_clr) begin
        first_time_q <= '0;
      end
    end
  end

  assign first_time = first_time_q;
`else
  assign first_time = '0;
`endif

endmodule

// File: tb/tb_automata_report_stage.sv
// Directed bench for automata_report_stage: instance A (DEPTH=2, 36 reports) and
// instance B (DEPTH=3, 12 reports, 4-bit counters).
module tb_automata_report_stage;

`ifdef AUTOMATA_RPT_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic clk;

  logic        a_reset, a_run, a_clr;
  logic [7:0]  a_sym, a_out_sym;
  logic [35:0] a_rpt, a_sticky;
  logic        a_out_reset, a_valid;
  logic [5:0]  a_idx;
  logic [15:0] a_hit, a_time;

  logic        b_reset, b_run, b_clr;
  logic [7:0]  b_sym, b_out_sym;
  logic [11:0] b_rpt, b_sticky;
  logic        b_out_reset, b_valid;
  logic [3:0]  b_idx;
  logic [3:0]  b_hit, b_time;

  int checks = 0;
  int errors = 0;

  automata_report_stage #(.SYM_W(8), .NUM_RPT(36), .DEPTH(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(a_reset), .run(a_run), .top_symbols(a_sym), .rpt_in(a_rpt),
    .rpt_clr(a_clr), .out_symbols(a_out_sym), .out_reset(a_out_reset),
    .rpt_sticky(a_sticky), .first_valid(a_valid), .first_idx(a_idx),
    .hit_count(a_hit), .first_time(a_time)
  );

  automata_report_stage #(.SYM_W(8), .NUM_RPT(12), .DEPTH(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset(b_reset), .run(b_run), .top_symbols(b_sym), .rpt_in(b_rpt),
    .rpt_clr(b_clr), .out_symbols(b_out_sym), .out_reset(b_out_reset),
    .rpt_sticky(b_sticky), .first_valid(b_valid), .first_idx(b_idx),
    .hit_count(b_hit), .first_time(b_time)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] exp_ts(input logic [63:0] v);
    return TS_EN ? v : 64'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic run, input logic [7:0] sym,
                               input logic [35:0] rpt, input logic clr);
    a_run = run;
    a_sym = sym;
    a_rpt = rpt;
    a_clr = clr;
    tick();
  endtask

  logic [35:0] rpt_v;

  initial begin
    a_reset = 1'b1; a_run = 1'b0; a_clr = 1'b0; a_sym = '0; a_rpt = '0;
    b_reset = 1'b1; b_run = 1'b0; b_clr = 1'b0; b_sym = '0; b_rpt = '0;
    repeat (4) tick();
    a_reset = 1'b0;
    b_reset = 1'b0;

    checkOutput("rst_a_sym",    a_out_sym,   0);
    checkOutput("rst_a_sticky", a_sticky,    0);
    checkOutput("rst_a_valid",  a_valid,     0);
    checkOutput("rst_a_idx",    a_idx,       0);
    checkOutput("rst_a_hit",    a_hit,       0);
    checkOutput("rst_a_time",   a_time,      0);
    checkOutput("rst_a_outrst", a_out_reset, 1);
    checkOutput("rst_b_outrst", b_out_reset, 1);
    tick();
    tick();
    checkOutput("a_outrst_low", a_out_reset, 0);

    // Symbol latency and hold while stalled
    applyStimulus(1'b1, 8'h11, '0, 1'b0);
    checkOutput("sym_lat1", a_out_sym, 8'h00);
    applyStimulus(1'b1, 8'h22, '0, 1'b0);
    checkOutput("sym_lat2", a_out_sym, 8'h11);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'hEE, '0, 1'b0);
      checkOutput("sym_hold", a_out_sym, 8'h11);
    end
    applyStimulus(1'b1, 8'h33, '0, 1'b0);
    checkOutput("sym_resume22", a_out_sym, 8'h22);
    applyStimulus(1'b1, 8'h00, '0, 1'b0);
    checkOutput("sym_resume33", a_out_sym, 8'h33);

    a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
    checkOutput("sym_flush", a_out_sym, 8'h00);

    // Hits in run cycles 4 and 7 after reset
    for (int c = 0; c < 8; c++) begin
      rpt_v = '0;
      if (c == 4) rpt_v = (36'd1 << 5) | (36'd1 << 9);
      if (c == 7) rpt_v = 36'd1 << 2;
      applyStimulus(1'b1, 8'(c), rpt_v, 1'b0);
      if (c == 4) begin
        checkOutput("c4_valid", a_valid, 1);
        checkOutput("c4_idx",   a_idx,   5);
        checkOutput("c4_hit",   a_hit,   1);
        checkOutput("c4_time",  a_time,  exp_ts(4));
      end
    end
    checkOutput("c7_sticky", a_sticky, 36'h0000_0224);
    checkOutput("c7_idx",    a_idx,    5);
    checkOutput("c7_time",   a_time,   exp_ts(4));
    checkOutput("c7_hit",    a_hit,    2);
    applyStimulus(1'b0, 8'h00, 36'd1 << 3, 1'b0);
    applyStimulus(1'b0, 8'h00, 36'd1 << 3, 1'b0);
    checkOutput("norun_sticky", a_sticky, 36'h0000_0224);
    checkOutput("norun_hit",    a_hit,    2);

    // Clear coinciding with a hit
    applyStimulus(1'b1, 8'h00, 36'd1 << 7, 1'b1);
    checkOutput("clrhit_sticky", a_sticky, 36'h0000_0080);
    checkOutput("clrhit_idx",    a_idx,    7);
    checkOutput("clrhit_hit",    a_hit,    1);
    checkOutput("clrhit_valid",  a_valid,  1);
    checkOutput("clrhit_time",   a_time,   exp_ts(8));
    applyStimulus(1'b0, 8'h00, '0, 1'b1);
    checkOutput("clr_sticky", a_sticky, 0);
    checkOutput("clr_valid",  a_valid,  0);
    checkOutput("clr_hit",    a_hit,    0);
    checkOutput("clr_time",   a_time,   0);
    applyStimulus(1'b1, 8'h00, (36'd1 << 35) | (36'd1 << 33), 1'b0);
    checkOutput("hi_idx",    a_idx,    33);
    checkOutput("hi_sticky", a_sticky, 36'hA_0000_0000);
    checkOutput("hi_time",   a_time,   exp_ts(9));
    a_run = 1'b0;
    a_rpt = '0;

    // Instance B: single-cycle reset pulse with run low
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    checkOutput("rdly_e0", b_out_reset, 0);
    tick();
    checkOutput("rdly_e1", b_out_reset, 0);
    tick();
    checkOutput("rdly_e2", b_out_reset, 1);
    tick();
    checkOutput("rdly_e3", b_out_reset, 0);

    // Saturation of a 4-bit hit counter
    b_run = 1'b1;
    b_rpt = 12'h001;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) checkOutput("sat_at15", b_hit, 15);
    end
    checkOutput("sat_hit",   b_hit,   15);
    checkOutput("sat_valid", b_valid, 1);
    checkOutput("sat_time",  b_time,  0);

    // Run-cycle counter is at 20 mod 16 = 4 here
    b_clr = 1'b1;
    b_rpt = 12'h008;
    tick();
    checkOutput("ts4_idx",  b_idx,  3);
    checkOutput("ts4_hit",  b_hit,  1);
    checkOutput("ts4_time", b_time, exp_ts(4));
    b_clr = 1'b0;
    b_rpt = 12'h000;
    repeat (11) tick();
    b_clr = 1'b1;
    b_rpt = 12'h002;
    tick();
    checkOutput("wrap_time",   b_time,   0);
    checkOutput("wrap_idx",    b_idx,    1);
    checkOutput("wrap_sticky", b_sticky, 12'h002);
    checkOutput("wrap_hit",    b_hit,    1);
    b_clr = 1'b0;
    b_run = 1'b0;
    b_rpt = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
